// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Status flags are decoded from the registered count, so every output
// changes only on a rising clock edge.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_ok, rd_ok;

  // Flags come straight from the count register.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign data_out     = dout_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Accept/reject decisions and next-state for pointers, count, data and errors.
  always_comb begin
    wr_ok   = wr && (!full || rd);   // a read at full frees the slot being written
    rd_ok   = rd && !empty;          // no fall-through when empty
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (wr_ok) wp_d = wp_q + PTR_ONE;
    if (rd_ok) begin
      rp_d   = rp_q + PTR_ONE;
      dout_d = mem_q[rp_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q && !clr_err) || (wr && !wr_ok);
    udf_d = (udf_q && !clr_err) || (rd && !rd_ok);
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents survive reset but writes are blocked during it.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem_q[wp_q] <= data_in;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised bench for fifo_sync_param: two instances (default 8x16 and
// 32x4 with tight thresholds) checked every cycle against a queue model.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, DEPTH=16 defaults
  logic        a_rst, a_wr, a_rd, a_clr;
  logic [7:0]  a_din, a_dout;
  logic        a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [4:0]  a_cnt;
  // Instance B: WIDTH=32, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1
  logic        b_rst, b_wr, b_rd, b_clr;
  logic [31:0] b_din, b_dout;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0]  b_cnt;

  fifo_sync_param u_a (
    .clk(clk), .reset(a_rst), .wr(a_wr), .data_in(a_din), .rd(a_rd), .clr_err(a_clr),
    .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_udf));

  fifo_sync_param #(.WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_b (
    .clk(clk), .reset(b_rst), .wr(b_wr), .data_in(b_din), .rd(b_rd), .clr_err(b_clr),
    .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_udf));

  // Reference model: a queue per instance plus expected output registers.
  int          dep_m [2] = '{16, 4};
  int          afl_m [2] = '{14, 3};
  int          ael_m [2] = '{2, 1};
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] dout_m [2];
  bit          ovf_m [2];
  bit          udf_m [2];

  int    n_chk  = 0;
  int    n_pass = 0;
  string phase  = "init";

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", phase, tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  function automatic int qsize(int i);
    return (i != 0) ? q1.size() : q0.size();
  endfunction

  task automatic model(int i, bit rst, bit w, bit r, bit c, logic [31:0] d);
    int n;
    bit wa, ra;
    n = qsize(i);
    if (!rst) begin
      if (i != 0) q1.delete(); else q0.delete();
      dout_m[i] = '0;
      ovf_m[i]  = 1'b0;
      udf_m[i]  = 1'b0;
    end else begin
      wa = w && (n < dep_m[i] || r);
      ra = r && (n > 0);
      if (ra) dout_m[i] = (i != 0) ? q1.pop_front() : q0.pop_front();
      if (wa) begin
        if (i != 0) q1.push_back(d); else q0.push_back(d & 32'hFF);
      end
      ovf_m[i] = (ovf_m[i] && !c) || (w && !wa);
      udf_m[i] = (udf_m[i] && !c) || (r && !ra);
    end
  endtask

  task automatic compare(int i);
    int n;
    n = qsize(i);
    if (i == 0) begin
      chk("cnt",  a_cnt,   n);
      chk("full", a_full,  n == dep_m[0]);
      chk("empt", a_empty, n == 0);
      chk("af",   a_af,    n >= afl_m[0]);
      chk("ae",   a_ae,    n <= ael_m[0]);
      chk("dout", a_dout,  dout_m[0]);
      chk("ovf",  a_ovf,   ovf_m[0]);
      chk("udf",  a_udf,   udf_m[0]);
    end else begin
      chk("cnt",  b_cnt,   n);
      chk("full", b_full,  n == dep_m[1]);
      chk("empt", b_empty, n == 0);
      chk("af",   b_af,    n >= afl_m[1]);
      chk("ae",   b_ae,    n <= ael_m[1]);
      chk("dout", b_dout,  dout_m[1]);
      chk("ovf",  b_ovf,   ovf_m[1]);
      chk("udf",  b_udf,   udf_m[1]);
    end
  endtask

  // One clock on instance i; the other instance idles (no state change).
  task automatic step(int i, bit rst, bit w, bit r, bit c, logic [31:0] d);
    a_rst = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
    b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
    if (i == 0) begin
      a_rst = rst; a_wr = w; a_rd = r; a_clr = c; a_din = d[7:0];
    end else begin
      b_rst = rst; b_wr = w; b_rd = r; b_clr = c; b_din = d;
    end
    @(posedge clk);
    #1;
    model(i, rst, w, r, c, d);
    compare(i);
  endtask

  task automatic fill_drain_wrap(int i);
    logic [31:0] v;
    phase = (i != 0) ? "B_fill" : "A_fill";
    for (int k = 0; k < dep_m[i]; k++) step(i, 1, 1, 0, 0, $urandom);
    step(i, 1, 1, 0, 0, 32'hDEAD_BEEF);           // rejected: overflow
    phase = (i != 0) ? "B_wrap" : "A_wrap";
    v = 32'h100;
    for (int k = 0; k < 40; k++) begin
      step(i, 1, 1, 1, (k == 0), v);              // clr_err on first: set wins? no new error
      v = v + 1;
    end
    phase = (i != 0) ? "B_drain" : "A_drain";
    for (int k = 0; k < dep_m[i]; k++) step(i, 1, 0, 1, 0, '0);
    step(i, 1, 0, 1, 0, '0);                      // rejected: underflow
  endtask

  task automatic random_run(int i, int cycles);
    phase = (i != 0) ? "B_rand" : "A_rand";
    for (int k = 0; k < cycles; k++)
      step(i, ($urandom_range(0, 99) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 9) == 0), $urandom);
  endtask

  logic [7:0] seq7 [7] = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

  initial begin
    a_rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = '0;
    b_rst = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = '0;

    phase = "reset";
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 0, '0);
      step(1, 0, 0, 0, 0, '0);
    end

    // Directed fill/drain of seven bytes
    phase = "seq7";
    for (int k = 0; k < 7; k++) step(0, 1, 1, 0, 0, {24'h0, seq7[k]});
    chk("cnt7", a_cnt, 7);
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 0, 1, 0, '0);
      chk("rd7", a_dout, seq7[k]);
    end
    chk("empty7", a_empty, 1);

    // Full, overflow, clear
    phase = "ovf";
    for (int k = 0; k < 16; k++) step(0, 1, 1, 0, 0, $urandom);
    step(0, 1, 1, 0, 0, 32'hEE);
    chk("ovf_set", a_ovf, 1);
    chk("ovf_cnt", a_cnt, 16);
    step(0, 1, 0, 0, 1, '0);
    chk("ovf_clr", a_ovf, 0);
    for (int k = 0; k < 16; k++) step(0, 1, 0, 1, 0, '0);

    // Empty corner: rejected read, then rd+wr together
    phase = "udf";
    step(0, 1, 0, 1, 0, '0);
    chk("udf_set", a_udf, 1);
    step(0, 1, 1, 1, 0, 32'h5A);
    chk("rw_empty_cnt", a_cnt, 1);
    step(0, 1, 0, 1, 0, '0);
    chk("rd_5a", a_dout, 8'h5A);
    step(0, 1, 0, 0, 1, '0);
    chk("udf_clr", a_udf, 0);

    // Full rd+wr streaming with wrap, then overflow/underflow edges
    fill_drain_wrap(0);

    // Reset mid-operation with count 9 and wr=rd=1
    phase = "midrst";
    for (int k = 0; k < 9; k++) step(0, 1, 1, 0, 0, $urandom);
    step(0, 0, 1, 1, 0, 32'h33);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_dout", a_dout, 0);
    step(0, 1, 1, 0, 0, 32'hC3);
    step(0, 1, 0, 1, 0, '0);
    chk("post_rst_rd", a_dout, 8'hC3);

    random_run(0, 400);

    // Narrow/wide configuration: thresholds hit exactly at 1, 2, 3
    phase = "B_thr";
    step(1, 1, 1, 0, 0, 32'h1111_0001);
    chk("b_ae1", b_ae, 1);
    step(1, 1, 1, 0, 0, 32'h1111_0002);
    chk("b_ae2", b_ae, 0);
    chk("b_af2", b_af, 0);
    step(1, 1, 1, 0, 0, 32'h1111_0003);
    chk("b_af3", b_af, 1);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 1, 0, '0);
    chk("b_rd3", b_dout, 32'h1111_0003);
    fill_drain_wrap(1);
    random_run(1, 300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
